// File: rtl/seq_cpu_pkg.sv
// Shared opcode encodings and FSM state type for the seq_cpu register-file machine.
package seq_cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_JZ   = 4'd8;
  localparam logic [3:0] OP_JC   = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC
  } state_e;

endpackage

// File: rtl/seq_cpu_alu.sv
// Combinational ALU for seq_cpu: arithmetic/logic result plus carry (borrow on SUB) and zero.
module seq_alu
  import seq_cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             cout_o,
  output logic             zero_o
);

  always_comb begin
    y_o    = '0;
    cout_o = 1'b0;
    case (op_i)
      OP_ADD: {cout_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB: begin
        y_o    = a_i - b_i;
        cout_o = (a_i < b_i);
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      default: ;
    endcase
  end

  assign zero_o = (y_o == '0);

endmodule

// File: rtl/seq_cpu.sv
// Programmable register-file CPU: loadable program RAM, two-cycle FETCH/EXEC sequencing,
// ALU ops with registered zero/carry flags, conditional jumps and start/busy/done handshake.
module seq_cpu
  import seq_cpu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NREGS      = 4,
  parameter int unsigned PROG_DEPTH = 16,
  localparam int unsigned RS = $clog2(NREGS),
  localparam int unsigned PW = $clog2(PROG_DEPTH),
  localparam int unsigned IW = 4 + 2 * RS + WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [PW-1:0]    prog_addr,
  input  logic [IW-1:0]    prog_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    pc,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  logic [IW-1:0]    mem [PROG_DEPTH];
  logic [IW-1:0]    ir_q;
  logic [WIDTH-1:0] rf_q [NREGS];
  state_e           state_q;

  logic [3:0]       op;
  logic [RS-1:0]    rd;
  logic [RS-1:0]    rs;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;
  logic             alu_zero;

  assign op  = ir_q[IW-1 -: 4];
  assign rd  = ir_q[IW-5 -: RS];
  assign rs  = ir_q[WIDTH +: RS];
  assign imm = ir_q[WIDTH-1:0];

  seq_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i   (rf_q[rd]),
    .b_i   (rf_q[rs]),
    .op_i  (op),
    .y_o   (alu_y),
    .cout_o(alu_cout),
    .zero_o(alu_zero)
  );

  // Program RAM survives reset; loads are locked out while a program runs.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      pc      <= '0;
      result  <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            busy    <= 1'b1;
            pc      <= '0;
          end
        end
        S_FETCH: begin
          ir_q    <= mem[pc];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          pc      <= pc + PW'(1);
          case (op)
            OP_LDI: begin
              rf_q[rd] <= imm;
              result   <= imm;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              rf_q[rd] <= alu_y;
              result   <= alu_y;
              zero     <= alu_zero;
              carry    <= alu_cout;
            end
            OP_JMP: pc <= imm[PW-1:0];
            OP_JZ:  if (zero)  pc <= imm[PW-1:0];
            OP_JC:  if (carry) pc <= imm[PW-1:0];
            OP_HALT: begin
              pc      <= pc;
              state_q <= S_IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
            default: ;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
